// File: rtl/job_dispatcher.sv
// rtl/job_dispatcher.sv - round-robin job dispatcher onto KERNEL_NUM kernel engines
// Optional stall counter enabled by defining JOB_DISPATCH_STALL_CNT_EN.
module job_dispatcher #(
    parameter int KERNEL_NUM = 8,
    parameter int KID_WIDTH  = 4,
    parameter int REG_WIDTH  = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_start,
    input  logic [REG_WIDTH-1:0]  system_register,
    input  logic [REG_WIDTH-1:0]  user_register,
    output logic                  new_job,
    output logic                  job_done,
    output logic [KERNEL_NUM-1:0] kernel_start,
    output logic [REG_WIDTH-1:0]  kernel_system_register,
    output logic [REG_WIDTH-1:0]  kernel_user_register,
    input  logic [KERNEL_NUM-1:0] kernel_done,
    output logic [KERNEL_NUM-1:0] kernel_busy,
    output logic [KID_WIDTH-1:0]  kernel_id,
    output logic [31:0]           jobs_dispatched,
    output logic [31:0]           jobs_completed,
    output logic                  overrun_err,
    output logic                  spurious_done_err,
    output logic [31:0]           stall_cycles
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_LAUNCH = 2'd2;
    localparam logic [1:0] ST_NOTIFY = 2'd3;

    logic [1:0]            state;
    logic [REG_WIDTH-1:0]  sys_buf;
    logic [REG_WIDTH-1:0]  usr_buf;
    logic [KID_WIDTH-1:0]  rr_ptr;
    logic [KID_WIDTH-1:0]  lo_idx;
    logic [KID_WIDTH-1:0]  hi_idx;
    logic [KID_WIDTH-1:0]  sel_idx;
    logic                  hi_found;
    logic [KERNEL_NUM-1:0] launch_vec;
    logic [KERNEL_NUM-1:0] done_acc;
    logic [KERNEL_NUM-1:0] busy_nxt;
    logic [31:0]           done_cnt;

    // Downward scan leaves the lowest free index overall (wrap case) and the
    // lowest free index at or above rr_ptr (preferred).
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int k = KERNEL_NUM - 1; k >= 0; k--) begin
            if (!kernel_busy[k]) begin
                lo_idx = KID_WIDTH'(k);
                if (KID_WIDTH'(k) >= rr_ptr) begin
                    hi_idx   = KID_WIDTH'(k);
                    hi_found = 1'b1;
                end
            end
        end
        sel_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        launch_vec = (state == ST_LAUNCH) ? (KERNEL_NUM'(1) << kernel_id) : '0;
        done_acc   = kernel_done & kernel_busy;
        busy_nxt   = (kernel_busy & ~done_acc) | launch_vec;
        done_cnt   = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            done_cnt = done_cnt + {31'd0, done_acc[k]};
        end
    end

    assign kernel_start           = launch_vec;
    assign new_job                = (state == ST_NOTIFY);
    assign job_done               = (state == ST_IDLE) && (kernel_busy == '0);
    assign kernel_system_register = sys_buf;
    assign kernel_user_register   = usr_buf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            sys_buf           <= '0;
            usr_buf           <= '0;
            rr_ptr            <= '0;
            kernel_id         <= '0;
            kernel_busy       <= '0;
            jobs_dispatched   <= '0;
            jobs_completed    <= '0;
            overrun_err       <= 1'b0;
            spurious_done_err <= 1'b0;
        end else begin
            kernel_busy    <= busy_nxt;
            jobs_completed <= jobs_completed + done_cnt;
            if (|(kernel_done & ~kernel_busy)) begin
                spurious_done_err <= 1'b1;
            end
            if (job_start && (state != ST_IDLE)) begin
                overrun_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (job_start) begin
                        sys_buf <= system_register;
                        usr_buf <= user_register;
                        state   <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (!(&kernel_busy)) begin
                        kernel_id <= sel_idx;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    rr_ptr          <= (kernel_id == KID_WIDTH'(KERNEL_NUM - 1)) ? '0 : kernel_id + 1'b1;
                    jobs_dispatched <= jobs_dispatched + 32'd1;
                    state           <= ST_NOTIFY;
                end
                ST_NOTIFY: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

`ifdef JOB_DISPATCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((state == ST_SELECT) && (&kernel_busy) && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: doc/job_dispatcher.md
Name: job_dispatcher

Overview:
- Downstream stage of the descriptor-fetching job manager.
- Consumes its job_start pulse and its 512-bit system_register and user_register.
- Assigns each job to a free kernel among KERNEL_NUM engines using round-robin, and tracks per-kernel busy state.
- Returns new_job and job_done to the job manager to pace descriptor fetches.

Parameters:
- KERNEL_NUM, 8, number of kernel engines (2..16).
- KID_WIDTH, 4, width of the kernel index; must satisfy 2^KID_WIDTH >= KERNEL_NUM.
- REG_WIDTH, 512, width of the system and user register words.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- job_start  in  1  one-cycle pulse: descriptor registers are valid.
- system_register  in  REG_WIDTH  descriptor system word.
- user_register  in  REG_WIDTH  descriptor user word.
- new_job  out  1  one-cycle pulse: job dispatched, ready for the next descriptor.
- job_done  out  1  level: dispatcher idle and all kernels idle.
- kernel_start  out  KERNEL_NUM  one-hot start pulse.
- kernel_system_register  out  REG_WIDTH  broadcast system word.
- kernel_user_register  out  REG_WIDTH  broadcast user word.
- kernel_done  in  KERNEL_NUM  per-kernel one-cycle completion pulse.
- kernel_busy  out  KERNEL_NUM  busy vector.
- kernel_id  out  KID_WIDTH  index of the last launched kernel.
- jobs_dispatched  out  32  launch counter.
- jobs_completed  out  32  accepted-completion counter.
- overrun_err  out  1  sticky: job_start arrived while not IDLE.
- spurious_done_err  out  1  sticky: kernel_done on a non-busy kernel.
- stall_cycles  out  32  see Optional Feature.

Behaviour:
- Reset:
  - rst sampled at posedge; all registers cleared; state=IDLE; rr_ptr=0.
  - All outputs 0, except job_done=1 (IDLE and busy==0).
  - Reset mid-operation abandons any buffered job; no kernel_start or new_job is issued for it.
- States:
  - IDLE: on job_start, latch system_register/user_register into the job buffer; go to SELECT.
  - SELECT: if ~&kernel_busy, pick the first free kernel scanning upward from rr_ptr with wrap modulo KERNEL_NUM; register it into kernel_id; go to LAUNCH. Otherwise stay in SELECT (stall).
  - LAUNCH: kernel_start[kernel_id]=1 for exactly this cycle. On exit: set kernel_busy[kernel_id]; rr_ptr<=(kernel_id+1)%KERNEL_NUM; jobs_dispatched+=1; go to NOTIFY.
  - NOTIFY: new_job=1 for exactly this cycle; go to IDLE.
- Register outputs:
  - kernel_system_register and kernel_user_register drive the job buffer.
  - They change only when job_start is accepted in IDLE, so they are stable through LAUNCH.
- Latency, job_start in cycle T with a free kernel:
  - SELECT in T+1.
  - kernel_start in T+2.
  - new_job in T+3.
  - Back to IDLE in T+4.
- job_done = (state==IDLE) & (kernel_busy==0), combinational.
  - It is low in T+1, which the job manager's post-start check requires.
- kernel_done[k]:
  - Clears kernel_busy[k] at the next edge and increments jobs_completed.
  - Several simultaneous done bits are all accepted; jobs_completed adds their popcount.
  - No same-cycle bypass: a kernel freed in cycle X is selectable in SELECT at X+1 and launched at X+2.
  - Done on a kernel with busy=0 is ignored for busy and the counter, and sets spurious_done_err.
  - A done bit coinciding with the LAUNCH set on the same kernel cannot occur (only free kernels are launched). If it does, the set wins.
- job_start outside IDLE: ignored (buffer and counters unchanged), sets overrun_err.
- Error flags clear only on rst.
- Counters wrap 0xFFFFFFFF->0.

Optional Feature:
- Macro JOB_DISPATCH_STALL_CNT_EN.
- Defined:
  - stall_cycles increments once per cycle spent in SELECT with all kernels busy.
  - Saturates at 0xFFFFFFFF; cleared by rst.
- Undefined: stall_cycles tied to 0 and no counter logic is generated. The port exists in both builds.

Test Plan:
- Reset, job_start at T with system_register=512'hA5 and user_register=512'h3C -> job_done low at T+1; kernel_start=8'h01 at T+2 with broadcast 0xA5/0x3C; new_job at T+3; kernel_busy=8'h01 at T+3. Then kernel_done=8'h01 -> job_done=1 next cycle, jobs_completed=1.
- Three back-to-back jobs, each issued after new_job, no done -> kernel_start 8'h01, 8'h02, 8'h04; kernel_id 0,1,2; jobs_dispatched=3.
- All 8 kernels busy, 9th job_start -> stays in SELECT, no new_job; stall_cycles counts (macro on) or reads 0 (off). kernel_done[5] at cycle X -> kernel_start=8'h20 at X+2, new_job at X+3.
- rr_ptr=7 with kernel 7 busy and kernel 0 free -> kernel 0 launched, rr_ptr=1.
- job_start while in SELECT with a different register value -> buffer unchanged, overrun_err=1, jobs_dispatched unchanged. kernel_done[3] with kernel 3 idle -> spurious_done_err=1, jobs_completed unchanged.
- rst asserted during LAUNCH -> next cycle all outputs 0 except job_done=1; no new_job pulse follows.
